// File: rtl/pe2ddr_burst_wr_pkg.sv
// Shared types and constants for the PE-to-DDR burst writer.
package pe2ddr_burst_wr_pkg;

  // Width of one DDR data beat (bits).
  localparam int DDR_W = 64;

  // AXI write response code for a successful write.
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Burst writer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } wr_state_t;

endpackage

// File: rtl/pe2ddr_burst_wr_fifo.sv
// ddr_wr_fifo: synchronous first-word-fall-through FIFO with an occupancy count.
// The head entry is visible on 'head' whenever the FIFO is not empty.
module ddr_wr_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == '0);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign head      = mem[rd_ptr_r];
  assign count     = count_r;

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Data storage; contents are don't-care until written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push_s) mem[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/pe2ddr_burst_wr.sv
// pe2ddr_burst_wr: buffers a valid/ready result stream and writes it to DDR
// as fixed-length AXI4 bursts (AW, then W, then B; no channel overlap).
// Optional feature macro: PE2DDR_WR_ERR_EN enables the sticky bresp error flag.
module pe2ddr_burst_wr
  import pe2ddr_burst_wr_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int BURST_LEN  = 16,
  parameter int AXI_ADDR_W = 32,
  parameter int LEN_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  done,
  output logic                  err,
  input  logic [AXI_ADDR_W-1:0] conf_base_addr,
  input  logic [LEN_W-1:0]      conf_beat_num,
  input  logic [DDR_W-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [AXI_ADDR_W-1:0] ddr_awaddr,
  output logic [7:0]            ddr_awlen,
  output logic                  ddr_awvalid,
  input  logic                  ddr_awready,
  output logic [DDR_W-1:0]      ddr_wdata,
  output logic                  ddr_wlast,
  output logic                  ddr_wvalid,
  input  logic                  ddr_wready,
  input  logic [1:0]            ddr_bresp,
  input  logic                  ddr_bvalid,
  output logic                  ddr_bready
);

  localparam int                    CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LEN_W-1:0]      BURST_MAX  = LEN_W'(BURST_LEN);
  localparam logic [AXI_ADDR_W-1:0] BEAT_BYTES = AXI_ADDR_W'(DDR_W / 8);

  wr_state_t             state_r, state_s;
  logic [LEN_W-1:0]      beat_num_r;
  logic [LEN_W-1:0]      rem_r;
  logic [LEN_W-1:0]      acc_r;
  logic [LEN_W-1:0]      beat_r;
  logic [AXI_ADDR_W-1:0] addr_r;
  logic                  done_r;
  logic [LEN_W-1:0]      blen_s;
  logic                  last_beat_s;
  logic                  fifo_ready_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  b_fire_s;
  logic [DDR_W-1:0]      fifo_head_s;
  logic [CNT_W-1:0]      fifo_count_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;

  ddr_wr_fifo #(
    .W     (DDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (in_data),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Current burst length: a full burst, or the shorter tail.
  assign blen_s       = (rem_r < BURST_MAX) ? rem_r : BURST_MAX;
  // AW is only offered once the whole burst is buffered, so W never starves mid-burst.
  assign fifo_ready_s = (LEN_W'(fifo_count_s) >= blen_s);
  assign last_beat_s  = (beat_r == (blen_s - LEN_W'(1)));

  assign in_ready   = (state_r != IDLE) && !fifo_full_s && (acc_r < beat_num_r);
  assign push_s     = in_valid && in_ready;
  assign pop_s      = ddr_wvalid && ddr_wready;
  assign b_fire_s   = ddr_bvalid && ddr_bready;
  assign ddr_awaddr = addr_r;
  assign ddr_awlen  = 8'(blen_s - LEN_W'(1));
  assign ddr_wdata  = fifo_head_s;
  assign done       = done_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic and channel handshake outputs decoded from the current state.
  always_comb begin
    state_s     = state_r;
    ddr_awvalid = 1'b0;
    ddr_wvalid  = 1'b0;
    ddr_wlast   = 1'b0;
    ddr_bready  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && (conf_beat_num != '0)) state_s = ADDR;
        else                                state_s = IDLE;
      end
      ADDR: begin
        ddr_awvalid = fifo_ready_s;
        if (fifo_ready_s && ddr_awready) state_s = DATA;
        else                             state_s = ADDR;
      end
      DATA: begin
        ddr_wvalid = !fifo_empty_s;
        ddr_wlast  = last_beat_s;
        if (!fifo_empty_s && ddr_wready && last_beat_s) state_s = RESP;
        else                                            state_s = DATA;
      end
      RESP: begin
        ddr_bready = 1'b1;
        if (ddr_bvalid) state_s = (rem_r == blen_s) ? IDLE : ADDR;
        else            state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Job configuration, burst/address progress, input acceptance and completion flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_num_r <= '0;
      rem_r      <= '0;
      acc_r      <= '0;
      beat_r     <= '0;
      addr_r     <= '0;
      done_r     <= 1'b1;
    end else begin
      if (push_s) acc_r <= acc_r + LEN_W'(1);
      case (state_r)
        IDLE: begin
          if (start) begin
            beat_num_r <= conf_beat_num;
            rem_r      <= conf_beat_num;
            addr_r     <= conf_base_addr;
            acc_r      <= '0;
            beat_r     <= '0;
            done_r     <= (conf_beat_num == '0);
          end
        end
        ADDR: begin
          if (ddr_awvalid && ddr_awready) beat_r <= '0;
        end
        DATA: begin
          if (pop_s) beat_r <= beat_r + LEN_W'(1);
        end
        RESP: begin
          if (b_fire_s) begin
            rem_r  <= rem_r - blen_s;
            addr_r <= addr_r + (AXI_ADDR_W'(blen_s) * BEAT_BYTES);
            if (rem_r == blen_s) done_r <= 1'b1;
          end
        end
        default: done_r <= done_r;
      endcase
    end
  end

`ifdef PE2DDR_WR_ERR_EN
  logic err_r;

  // Sticky error on any non-OKAY write response; cleared when a new job is started.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if ((state_r == IDLE) && start) begin
      err_r <= 1'b0;
    end else if (b_fire_s && (ddr_bresp != AXI_RESP_OKAY)) begin
      err_r <= 1'b1;
    end
  end

  assign err = err_r;
`else
  logic unused_bresp_s;
  assign unused_bresp_s = ^ddr_bresp;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_pe2ddr_burst_wr.sv
// Self-checking bench for pe2ddr_burst_wr: table of directed jobs plus
// hand-written reset, zero-length and mid-burst reset sequences.
`timescale 1ns/1ps
module tb_pe2ddr_burst_wr;
  import pe2ddr_burst_wr_pkg::*;

  localparam int FIFO_DEPTH = 64;
  localparam int BURST_LEN  = 16;
  localparam int AXI_ADDR_W = 32;
  localparam int LEN_W      = 16;
  localparam int BEAT_BYTES = DDR_W / 8;
`ifdef PE2DDR_WR_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  done;
  logic                  err;
  logic [AXI_ADDR_W-1:0] conf_base_addr;
  logic [LEN_W-1:0]      conf_beat_num;
  logic [DDR_W-1:0]      in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [AXI_ADDR_W-1:0] ddr_awaddr;
  logic [7:0]            ddr_awlen;
  logic                  ddr_awvalid;
  logic                  ddr_awready;
  logic [DDR_W-1:0]      ddr_wdata;
  logic                  ddr_wlast;
  logic                  ddr_wvalid;
  logic                  ddr_wready;
  logic [1:0]            ddr_bresp;
  logic                  ddr_bvalid;
  logic                  ddr_bready;

  pe2ddr_burst_wr #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .BURST_LEN  (BURST_LEN),
    .AXI_ADDR_W (AXI_ADDR_W),
    .LEN_W      (LEN_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .done           (done),
    .err            (err),
    .conf_base_addr (conf_base_addr),
    .conf_beat_num  (conf_beat_num),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .ddr_awaddr     (ddr_awaddr),
    .ddr_awlen      (ddr_awlen),
    .ddr_awvalid    (ddr_awvalid),
    .ddr_awready    (ddr_awready),
    .ddr_wdata      (ddr_wdata),
    .ddr_wlast      (ddr_wlast),
    .ddr_wvalid     (ddr_wvalid),
    .ddr_wready     (ddr_wready),
    .ddr_bresp      (ddr_bresp),
    .ddr_bvalid     (ddr_bvalid),
    .ddr_bready     (ddr_bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          beat_num;
    logic [31:0] base;
    int          gap;            // in_valid offered every 'gap' cycles
    bit          wrand;          // random wready
    int          hold;           // cycles awready is held low
    bit          err_first;      // bresp=SLVERR on first burst
    bit          start_in_data;  // extra start pulse while in DATA
    int          exp_bursts;
    int          exp_last_awlen;
    int          exp_max_occ;    // 0 = not checked
  } vec_t;

  vec_t vecs[7];
  int   errors = 0;
  int   checks = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DDR_W-1:0] mkdata(int job, int idx);
    return {8'(job), 24'(idx), 32'hA5A5_0000 ^ 32'(idx)};
  endfunction

  task automatic run_job(int job, vec_t v);
    int pushed = 0, popped = 0, bursts = 0, bdone = 0, beat_in = 0;
    int cur_blen = 0, rem = 0, blen = 0, occ = 0, max_occ = 0, cyc = 0, last_awlen = -1;
    bit b_pend = 0, finished = 0, did_start = 0, awf, wf, bf;
    @(negedge clk);
    conf_base_addr = v.base;
    conf_beat_num  = LEN_W'(v.beat_num);
    start          = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("job%0d_done_low", job), done, 0);
    while (!finished && cyc < 3000) begin
      in_valid    = (pushed < v.beat_num) && (cyc % v.gap == 0);
      in_data     = mkdata(job, pushed);
      ddr_awready = (cyc >= v.hold);
      ddr_wready  = v.wrand ? 1'($urandom_range(0, 1)) : 1'b1;
      ddr_bvalid  = b_pend;
      ddr_bresp   = (v.err_first && bdone == 0) ? 2'b10 : 2'b00;
      start       = 1'b0;
      if (v.start_in_data && ddr_wvalid && !did_start) begin
        start         = 1'b1;
        conf_beat_num = 16'd7;
        did_start     = 1'b1;
      end
      #1;
      awf = ddr_awvalid && ddr_awready;
      wf  = ddr_wvalid && ddr_wready;
      bf  = ddr_bvalid && ddr_bready;
      rem  = v.beat_num - popped;
      blen = (rem < BURST_LEN) ? rem : BURST_LEN;
      if (ddr_awvalid)
        check($sformatf("job%0d_aw_fifo_has_burst", job), ((pushed - popped) >= blen), 1);
      if (awf) begin
        check($sformatf("job%0d_awaddr_b%0d", job, bursts), ddr_awaddr,
              v.base + 32'(bursts * BEAT_BYTES * BURST_LEN));
        check($sformatf("job%0d_awlen_b%0d", job, bursts), ddr_awlen, blen - 1);
        cur_blen   = blen;
        beat_in    = 0;
        last_awlen = ddr_awlen;
        bursts++;
      end
      if (wf) begin
        check($sformatf("job%0d_wdata_%0d", job, popped), ddr_wdata, mkdata(job, popped));
        check($sformatf("job%0d_wlast_%0d", job, popped), ddr_wlast, (beat_in == cur_blen - 1));
        popped++;
        beat_in++;
        if (ddr_wlast) b_pend = 1'b1;
      end
      if (bf) begin
        b_pend = 1'b0;
        bdone++;
        finished = (popped == v.beat_num);
      end
      if (in_valid && in_ready) pushed++;
      occ = pushed - popped;
      if (occ > max_occ) max_occ = occ;
      if (occ > FIFO_DEPTH) check($sformatf("job%0d_fifo_overflow", job), occ, FIFO_DEPTH);
      @(negedge clk);
      cyc++;
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL job%0d_timeout: got %0d beats written expected %0d", job, popped, v.beat_num);
    end
    in_valid    = 1'b0;
    ddr_bvalid  = 1'b0;
    ddr_awready = 1'b0;
    ddr_wready  = 1'b0;
    start       = 1'b0;
    @(negedge clk);
    check($sformatf("job%0d_done_high", job), done, 1);
    check($sformatf("job%0d_err", job), err, ERR_EN && v.err_first);
    check($sformatf("job%0d_bursts", job), bursts, v.exp_bursts);
    check($sformatf("job%0d_last_awlen", job), last_awlen, v.exp_last_awlen);
    check($sformatf("job%0d_in_ready_idle", job), in_ready, 0);
    if (v.exp_max_occ > 0) check($sformatf("job%0d_max_fifo", job), max_occ, v.exp_max_occ);
  endtask

  initial begin
    int aw_seen, not_done, cyc;
    //        beats base      gap rnd hold errf sid bursts lastlen maxocc
    vecs[0] = '{32, 32'h1000, 1, 0, 0,   0, 0, 2, 15, 0};
    vecs[1] = '{20, 32'h2000, 1, 0, 0,   0, 0, 2, 3,  0};
    vecs[2] = '{40, 32'h3000, 4, 1, 0,   0, 0, 3, 7,  0};
    vecs[3] = '{80, 32'h4000, 1, 0, 100, 0, 0, 5, 15, 64};
    vecs[4] = '{5,  32'h5000, 1, 0, 0,   0, 1, 1, 4,  0};
    vecs[5] = '{16, 32'h6000, 1, 0, 0,   1, 0, 1, 15, 0};
    vecs[6] = '{3,  32'h7000, 1, 1, 0,   0, 0, 1, 2,  0};

    rst = 1'b1; start = 1'b0; conf_base_addr = '0; conf_beat_num = '0;
    in_data = '0; in_valid = 1'b0; ddr_awready = 1'b0; ddr_wready = 1'b0;
    ddr_bresp = 2'b00; ddr_bvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_done", done, 1);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_awvalid", ddr_awvalid, 0);
    check("rst_wvalid", ddr_wvalid, 0);
    check("rst_wlast", ddr_wlast, 0);
    check("rst_bready", ddr_bready, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_job(i + 1, vecs[i]);

    // Zero-length job: nothing issued, done never drops.
    @(negedge clk);
    conf_base_addr = 32'h8000;
    conf_beat_num  = '0;
    start          = 1'b1;
    aw_seen = 0; not_done = 0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ddr_awvalid || in_ready) aw_seen++;
      if (!done) not_done++;
      @(negedge clk);
    end
    check("zero_no_activity", aw_seen, 0);
    check("zero_done_stays", not_done, 0);

    // Reset while a burst is stalled in DATA.
    conf_base_addr = 32'h9000;
    conf_beat_num  = 16'd16;
    start          = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    ddr_awready = 1'b1;
    ddr_wready  = 1'b0;
    cyc = 0;
    while (!ddr_wvalid && cyc < 200) begin
      in_valid = 1'b1;
      in_data  = mkdata(99, cyc);
      @(negedge clk);
      cyc++;
    end
    check("midrst_reached_data", ddr_wvalid, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_done", done, 1);
    check("midrst_wvalid", ddr_wvalid, 0);
    check("midrst_wlast", ddr_wlast, 0);
    check("midrst_awvalid", ddr_awvalid, 0);
    check("midrst_in_ready", in_ready, 0);
    in_valid    = 1'b0;
    ddr_awready = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Normal operation resumes after the abandoned job.
    run_job(10, vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
